// File: rtl/seq_bus_datapath.sv
// Single-bus register datapath with a built-in T-step sequencer: Ra->Y, Rb+ALU->Z, Z->Rd (ZHI->HI for MUL).
// A host port preloads and inspects the register file while the sequencer is idle.
module seq_bus_datapath #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter bit          R0_ZERO  = 1'b1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rd,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] bus_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpShl = 3'b100;
    localparam logic [2:0] OpShr = 3'b101;
    localparam logic [2:0] OpNot = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [2:0] {StIdle, StLoadY, StExec, StWbLo, StWbHi} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  hi_q, lo_q, y_q, zhi_q, zlo_q;
    logic [2:0]        op_q;
    logic [AW-1:0]     ra_q, rb_q, rd_q;
    logic              busy_q, done_q;

    logic [WIDTH-1:0]   ra_val, rb_val, bus;
    logic [WIDTH-1:0]   alu_hi, alu_lo;
    logic [2*WIDTH-1:0] prod;
    logic [SW-1:0]      shamt;

    // R0 reads as zero when hardwired.
    assign ra_val   = (R0_ZERO && ra_q == '0) ? '0 : regs_q[ra_q];
    assign rb_val   = (R0_ZERO && rb_q == '0) ? '0 : regs_q[rb_q];
    assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    always_comb begin
        bus = '0;
        unique case (state_q)
            StLoadY: bus = ra_val;
            StExec:  bus = rb_val;
            StWbLo:  bus = zlo_q;
            StWbHi:  bus = zhi_q;
            default: bus = '0;
        endcase
    end

    assign shamt = bus[SW-1:0];
    // Sign-extend both operands so the low 2*WIDTH bits hold the signed product.
    assign prod  = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        unique case (op_q)
            OpAdd: alu_lo = y_q + bus;
            OpSub: alu_lo = y_q - bus;
            OpAnd: alu_lo = y_q & bus;
            OpOr:  alu_lo = y_q | bus;
            OpShl: alu_lo = y_q << shamt;
            OpShr: alu_lo = y_q >> shamt;
            OpNot: alu_lo = ~y_q;
            OpMul: begin
                alu_lo = prod[WIDTH-1:0];
                alu_hi = prod[2*WIDTH-1:WIDTH];
            end
            default: alu_lo = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StIdle;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            y_q    <= '0;
            zhi_q  <= '0;
            zlo_q  <= '0;
            op_q   <= OpAdd;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q && load_en && !(R0_ZERO && load_addr == '0)) begin
                regs_q[load_addr] <= load_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        ra_q    <= ra;
                        rb_q    <= rb;
                        rd_q    <= rd;
                        busy_q  <= 1'b1;
                        state_q <= StLoadY;
                    end
                end
                StLoadY: begin
                    y_q     <= bus;
                    state_q <= StExec;
                end
                StExec: begin
                    zhi_q   <= alu_hi;
                    zlo_q   <= alu_lo;
                    state_q <= StWbLo;
                end
                StWbLo: begin
                    if (op_q == OpMul) begin
                        lo_q    <= bus;
                        state_q <= StWbHi;
                    end else begin
                        if (!(R0_ZERO && rd_q == '0)) regs_q[rd_q] <= bus;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StWbHi: begin
                    hi_q    <= bus;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_out = bus;
    assign busy    = busy_q;
    assign done    = done_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

endmodule

// File: tb/tb_seq_bus_datapath.sv
// Directed bench for seq_bus_datapath: a transaction-level queue model predicts bus/busy/done/regs per cycle.
module tb_seq_bus_datapath;

    logic        Clock = 1'b0;
    logic        Clear, start, load_en;
    logic [2:0]  op;
    logic [3:0]  ra, rb, rd, load_addr, dbg_addr;
    logic [31:0] load_data, dbg_data, hi_out, lo_out, bus_out;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    seq_bus_datapath #(.WIDTH(32), .NUM_REGS(16), .R0_ZERO(1'b1)) dut (
        .Clock(Clock), .Clear(Clear), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .hi_out(hi_out), .lo_out(lo_out),
        .bus_out(bus_out), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit          busy;
        bit          done;
        logic [31:0] bus;
        bit          wr_reg;
        bit          wr_lo;
        bit          wr_hi;
        int          idx;
        logic [31:0] val;
    } rec_t;

    logic [31:0] m_regs [16];
    logic [31:0] m_hi, m_lo;
    rec_t        q[$];
    rec_t        cur;

    function automatic rec_t mk(bit b, bit d, logic [31:0] v);
        rec_t r;
        r.busy = b; r.done = d; r.bus = v;
        r.wr_reg = 0; r.wr_lo = 0; r.wr_hi = 0; r.idx = 0; r.val = '0;
        return r;
    endfunction

    function automatic logic [31:0] mread(input int a);
        return (a == 0) ? 32'h0 : m_regs[a];
    endfunction

    function automatic logic [63:0] model_alu(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int     sa, sb;
        longint p;
        logic [4:0] sh;
        sh = b[4:0];
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        case (o)
            3'd0: return {32'h0, a + b};
            3'd1: return {32'h0, a - b};
            3'd2: return {32'h0, a & b};
            3'd3: return {32'h0, a | b};
            3'd4: return {32'h0, a << sh};
            3'd5: return {32'h0, a >> sh};
            3'd6: return {32'h0, ~a};
            default: return p;
        endcase
    endfunction

    initial cur = mk(0, 0, 0);

    always @(posedge Clock) begin
        bit prev_busy;
        logic [31:0] a, b;
        logic [63:0] res;
        rec_t r;
        if (Clear) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_hi = '0; m_lo = '0;
            q.delete();
            cur = mk(0, 0, 0);
        end else begin
            prev_busy = cur.busy;
            if (!prev_busy && load_en && load_addr != 0) m_regs[load_addr] = load_data;
            if (!prev_busy && start) begin
                a   = mread(ra);
                b   = mread(rb);
                res = model_alu(op, a, b);
                q.push_back(mk(1, 0, a));
                q.push_back(mk(1, 0, b));
                q.push_back(mk(1, 0, res[31:0]));
                if (op == 3'd7) begin
                    r = mk(1, 0, res[63:32]); r.wr_lo = 1; r.val = res[31:0]; q.push_back(r);
                    r = mk(0, 1, 0); r.wr_hi = 1; r.val = res[63:32]; q.push_back(r);
                end else begin
                    r = mk(0, 1, 0); r.wr_reg = 1; r.idx = rd; r.val = res[31:0]; q.push_back(r);
                end
            end
            cur = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0);
            if (cur.wr_reg && cur.idx != 0) m_regs[cur.idx] = cur.val;
            if (cur.wr_lo) m_lo = cur.val;
            if (cur.wr_hi) m_hi = cur.val;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("bus_out", bus_out, cur.bus);
            chk("busy", busy, cur.busy);
            chk("done", done, cur.done);
            chk("hi_out", hi_out, m_hi);
            chk("lo_out", lo_out, m_lo);
            chk("dbg_data", dbg_data, mread(dbg_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic host_load(input logic [3:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        step();
        load_en = 0;
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge Clock);
        chk(name, dbg_data, exp);
        step();
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (done !== 1'b1 && n < 12);
        chk(name, n, exp_lat);
        step();
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] d, input int lat);
        op = o; ra = a; rb = b; rd = d; start = 1;
        step();
        start = 0;
        wait_done(name, lat);
    endtask

    initial begin
        Clear = 1; start = 0; load_en = 0; op = 0; ra = 0; rb = 0; rd = 0;
        load_addr = 0; load_data = 0; dbg_addr = 0;
        step();
        chk_en = 1;
        step();
        Clear = 0;
        @(negedge Clock);
        chk("reset_busy", busy, 0);
        chk("reset_bus", bus_out, 0);
        step();

        // 1: ADD
        host_load(2, 32'd5);
        host_load(3, 32'd7);
        op = 3'd0; ra = 2; rb = 3; rd = 4; start = 1;
        step();
        start = 0;
        @(negedge Clock); chk("t1_bus_a", bus_out, 32'd5);
        @(negedge Clock); chk("t1_bus_b", bus_out, 32'd7);
        @(negedge Clock); chk("t1_bus_z", bus_out, 32'd12);
        @(negedge Clock); chk("t1_done", done, 1);
        step();
        peek("t1_r4", 4, 32'd12);

        // 2: SUB
        run_op("t2_lat", 3'd1, 2, 3, 5, 4);
        peek("t2_r5", 5, 32'hFFFF_FFFE);

        // 3: MUL
        host_load(6, 32'hFFFF_FFFF);
        host_load(7, 32'd2);
        run_op("t3_lat", 3'd7, 6, 7, 8, 5);
        chk("t3_lo", lo_out, 32'hFFFF_FFFE);
        chk("t3_hi", hi_out, 32'hFFFF_FFFF);
        peek("t3_r8", 8, 32'd0);

        // other ALU ops on R6=FFFFFFFF, R7=2
        run_op("and_lat", 3'd2, 6, 7, 11, 4); peek("and_r11", 11, 32'd2);
        run_op("or_lat",  3'd3, 6, 7, 11, 4); peek("or_r11", 11, 32'hFFFF_FFFF);
        run_op("shr_lat", 3'd5, 6, 7, 11, 4); peek("shr_r11", 11, 32'h3FFF_FFFF);
        run_op("not_lat", 3'd6, 7, 6, 11, 4); peek("not_r11", 11, 32'hFFFF_FFFD);

        // 4: R0 hardwired, shift amount wraps
        host_load(0, 32'h1234);
        run_op("t4_lat", 3'd0, 0, 2, 0, 4);
        peek("t4_r0", 0, 32'd0);
        host_load(9, 32'd33);
        run_op("t4_shl", 3'd4, 2, 9, 10, 4);
        peek("t4_r10", 10, 32'd10);

        // 5: Clear during EXEC
        op = 3'd0; ra = 2; rb = 3; rd = 4; start = 1;
        step();
        start = 0;
        step();
        Clear = 1;
        step();
        Clear = 0;
        @(negedge Clock);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        step();
        for (int i = 0; i < 16; i++) peek("t5_reg", i[3:0], 32'd0);

        // 6: host write and start while busy are dropped
        host_load(2, 32'd5);
        host_load(3, 32'd7);
        op = 3'd0; ra = 2; rb = 3; rd = 4; start = 1;
        step();
        op = 3'd1; rd = 11; load_en = 1; load_addr = 3; load_data = 32'h99;
        step();
        start = 0; load_en = 0;
        wait_done("t6_lat", 3);
        repeat (3) step();
        peek("t6_r3", 3, 32'd7);
        peek("t6_r11", 11, 32'd0);
        peek("t6_r4", 4, 32'd12);
        // same-edge load + accept: op sees the new value
        load_en = 1; load_addr = 2; load_data = 32'd100;
        op = 3'd0; ra = 2; rb = 3; rd = 12; start = 1;
        step();
        load_en = 0; start = 0;
        wait_done("t6b_lat", 4);
        peek("t6b_r12", 12, 32'd107);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
